// File: rtl/seq_pkg.sv
// Shared types and widths for the VGA display step sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package seq_pkg;

   localparam int STEP_W  = 4;
   localparam int DWELL_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } seq_state_t;

   // A programmed dwell of zero seconds still shows the step for one second.
   function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
      return (d == '0) ? DWELL_W'(1) : d;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Latency: tick is combinational from the registered count (asserts in the terminal-count cycle).
// Backpressure: en low holds the count, clr zeroes it (clr wins over en).
//
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clr       : zero the count (no tick in that cycle)
//   en        : advance the count this cycle
//   tick      : high in the cycle the count sits at TICK_DIV-1 while enabled
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/step_sequencer.sv
// Steps a 4-bit index through NUM_STEPS display steps, dwelling a programmed number of seconds each.
// Latency: outputs registered; one LOAD cycle between steps; skip ends a step on the edge it is sampled.
// Backpressure: pause freezes the second prescaler and dwell count; start is ignored while busy.
//
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   start             : pulse, begins at step 0 when idle
//   pause             : level, holds the current step's timing
//   skip              : pulse, ends the current step now
//   loop              : level, sampled at the end of the last step (1 = restart)
//   dwell             : seconds for the current step, looked up externally from step
//   step              : current step index
//   busy              : sequence in progress
//   step_done         : one-cycle pulse when any step ends
//   seq_done          : one-cycle pulse when the last step ends
module step_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_STEPS = 9,
   parameter int TICK_DIV  = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause,
   input  logic               skip,
   input  logic               loop,
   input  logic [DWELL_W-1:0] dwell,
   output logic [STEP_W-1:0]  step,
   output logic               busy,
   output logic               step_done,
   output logic               seq_done
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   seq_state_t         state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [DWELL_W-1:0] remaining_q, remaining_d;
   logic               busy_q, busy_d;
   logic               step_done_q, step_done_d;
   logic               seq_done_q, seq_done_d;

   logic               presc_clr;
   logic               presc_en;
   logic               tick;
   logic               end_step;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .clr  (presc_clr),
      .en   (presc_en),
      .tick (tick)
   );

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      remaining_d = remaining_q;
      step_done_d = 1'b0;
      seq_done_d  = 1'b0;
      presc_clr   = 1'b0;
      presc_en    = 1'b0;
      end_step    = 1'b0;

      case (state_q)
         IDLE: begin
            step_d = '0;
            if (start) begin
               state_d = LOAD;
            end
         end

         LOAD: begin
            remaining_d = eff_dwell(dwell);
            presc_clr   = 1'b1;
            state_d     = RUN;
         end

         RUN: begin
            presc_en = 1'b1;
            // skip beats tick beats pause; the end check precedes the
            // decrement so remaining never wraps below 1.
            if (skip) begin
               end_step = 1'b1;
            end else if (tick) begin
               if (remaining_q > DWELL_W'(1)) begin
                  remaining_d = remaining_q - DWELL_W'(1);
               end else begin
                  end_step = 1'b1;
               end
            end
            if (!end_step && pause) begin
               state_d = PAUSED;
            end
         end

         PAUSED: begin
            if (skip) begin
               end_step = 1'b1;
            end else if (!pause) begin
               state_d = RUN;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (end_step) begin
         step_done_d = 1'b1;
         if (step_q >= LAST_STEP) begin
            seq_done_d = 1'b1;
            step_d     = '0;
            state_d    = loop ? LOAD : IDLE;
         end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = LOAD;
         end
      end

      // busy is registered, so it follows the state being entered.
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         step_done_q <= 1'b0;
         seq_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         step_done_q <= step_done_d;
         seq_done_q  <= seq_done_d;
      end
   end

   assign step      = step_q;
   assign busy      = busy_q;
   assign step_done = step_done_q;
   assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

   localparam int NS = 3;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       skip = 1'b0;
   logic       loop = 1'b0;
   logic [3:0] dwell;
   logic [3:0] step;
   logic       busy;
   logic       step_done;
   logic       seq_done;

   logic [3:0] dwell_tab [0:NS-1];

   assign dwell = (step < 4'(NS)) ? dwell_tab[step] : 4'd1;

   always #5 clk = ~clk;

   step_sequencer #(
      .NUM_STEPS (NS),
      .TICK_DIV  (TD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .skip      (skip),
      .loop      (loop),
      .dwell     (dwell),
      .step      (step),
      .busy      (busy),
      .step_done (step_done),
      .seq_done  (seq_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // A step needs eff(dwell)*TD un-paused cycles; it ends when they are used up or on skip.
   typedef struct {
      int step_after;
      bit seq;
   } exp_t;

   exp_t sb[$];
   int   m_mode;      // 0 idle, 1 loading, 2 active
   bit   m_paused;
   int   m_step;
   int   m_elapsed;
   int   m_needed;

   always @(posedge clk or posedge rst) begin
      bit ended;
      bit last;
      if (rst) begin
         m_mode = 0; m_paused = 0; m_step = 0; m_elapsed = 0; m_needed = 0;
         sb.delete();
      end else begin
         ended = 0;
         case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
               m_needed  = ((dwell_tab[m_step] == 0) ? 1 : int'(dwell_tab[m_step])) * TD;
               m_elapsed = 0;
               m_paused  = 0;
               m_mode    = 2;
            end
            default: begin
               if (!m_paused) begin
                  m_elapsed++;
                  if (skip || m_elapsed == m_needed) ended = 1;
                  else if (pause) m_paused = 1;
               end else begin
                  if (skip) ended = 1;
                  else if (!pause) m_paused = 0;
               end
            end
         endcase
         if (ended) begin
            last = (m_step == NS - 1);
            sb.push_back('{step_after: (last ? 0 : m_step + 1), seq: last});
            m_step = last ? 0 : m_step + 1;
            m_mode = (last && !loop) ? 0 : 1;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("step", int'(step), m_step);
         chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("step_done", int'(step_done), 1);
            chk("seq_done", int'(seq_done), int'(e.seq));
            chk("step_after_done", int'(step), e.step_after);
         end else begin
            chk("no_step_done", int'(step_done), 0);
            chk("no_seq_done", int'(seq_done), 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic set_tab(input int a, input int b, input int c);
      dwell_tab[0] = 4'(a);
      dwell_tab[1] = 4'(b);
      dwell_tab[2] = 4'(c);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         cyc(1);
         k++;
      end
      chk("wait_idle_in_budget", int'(busy), 0);
   endtask

   task automatic wait_step(input int s, input int budget);
      int k = 0;
      while (int'(step) != s && k < budget) begin
         cyc(1);
         k++;
      end
      chk("wait_step_in_budget", int'(step), s);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      set_tab(2, 2, 2);
      cyc(2);
      chk("reset_step", int'(step), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_step_done", int'(step_done), 0);
      chk("reset_seq_done", int'(seq_done), 0);
      rst = 1'b0;
      cyc(2);

      // basic run
      pulse_start();
      wait_idle(100);
      cyc(2);

      // zero dwell on step 1
      set_tab(2, 0, 2);
      pulse_start();
      wait_idle(100);
      cyc(2);

      // pause for 10 cycles mid-step 0
      set_tab(2, 2, 2);
      pulse_start();
      cyc(4);
      pause = 1'b1;
      cyc(10);
      pause = 1'b0;
      wait_idle(100);
      cyc(2);

      // skip 2 cycles into step 1, then skip together with pause
      pulse_start();
      wait_step(1, 50);
      cyc(2);
      skip = 1'b1;
      cyc(1);
      skip = 1'b0;
      wait_idle(100);
      pulse_start();
      wait_step(1, 50);
      cyc(2);
      skip = 1'b1;
      pause = 1'b1;
      cyc(1);
      skip = 1'b0;
      pause = 1'b0;
      wait_idle(100);
      cyc(2);

      // loop, with a start pulse while busy
      loop = 1'b1;
      pulse_start();
      cyc(40);
      pulse_start();
      cyc(20);
      loop = 1'b0;
      wait_idle(100);
      cyc(2);

      // asynchronous reset during step 2
      pulse_start();
      wait_step(2, 50);
      cyc(2);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_step", int'(step), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_step_done", int'(step_done), 0);
      chk("async_rst_seq_done", int'(seq_done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1);
      pulse_start();
      wait_idle(100);
      cyc(2);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         set_tab($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         loop = ($urandom_range(0, 3) == 0);
         pulse_start();
         for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            skip  = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 9) == 0);
            cyc(1);
         end
         skip = 1'b0;
         start = 1'b0;
         pause = 1'b0;
         loop = 1'b0;
         wait_idle(300);
         cyc(2);
      end

      cyc(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Top-level step controller for the VGA display flow. It drives the 4-bit `step` bus that the timers and renderers decode, holding each step for a programmable number of one-second ticks. It supports pause, skip and optional looping, and pulses `step_done` and `seq_done` so downstream blocks can react to transitions without decoding `step` themselves.

## Interface
- `NUM_STEPS`, default 9: number of steps in the sequence, indexed 0..NUM_STEPS-1; legal range 2..16.
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; simulation uses 4.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: single-cycle pulse that begins the sequence at step 0; ignored while `busy`.
- `pause`  in  1: level; freezes the tick prescaler and the dwell count.
- `skip`  in  1: single-cycle pulse that ends the current step immediately.
- `loop`  in  1: level, sampled when the last step ends; 1 = restart at step 0.
- `dwell`  in  4: seconds for the current step, supplied combinationally from `step`; 0 is treated as 1.
- `step`  out  4: current step index.
- `busy`  out  1: high in LOAD, RUN and PAUSED.
- `step_done`  out  1: one-cycle pulse when a step ends.
- `seq_done`  out  1: one-cycle pulse when the last step ends.

## Operation
- States: IDLE, LOAD, RUN, PAUSED.
- IDLE:
  - `step`=0, `busy`=0.
  - `start` → LOAD.
- LOAD (exactly 1 cycle):
  - Latch `remaining` = (`dwell`==0 ? 1 : `dwell`).
  - Clear the prescaler.
  - → RUN.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; its terminal count is the tick.
  - On a tick with `remaining`>1: decrement `remaining`.
  - On a tick with `remaining`==1, or on `skip`: the step ends.
  - `pause`=1 with no end event → PAUSED.
- PAUSED:
  - Prescaler and `remaining` hold.
  - `pause`=0 → RUN, resuming from the held count.
  - `skip` ends the step.
- Step end, non-last step: pulse `step_done`, set `step`+1, → LOAD.
- Step end, last step (`step`==NUM_STEPS-1): pulse both `step_done` and `seq_done`, set `step`=0.
  - `loop`=1 → LOAD.
  - `loop`=0 → IDLE.
- Priority in the same cycle: `skip` > tick > `pause`. A tick that ends the step overrides a simultaneous `pause`.
- `start` while `busy` is ignored; no restart occurs.
- `rst` mid-operation:
  - Immediately returns to IDLE with `step`=0.
  - Clears the prescaler and `remaining`.
  - All pulse outputs go to 0.
- Widths:
  - `remaining` is 4 bits and can never underflow: the end condition is checked before any decrement.
  - The prescaler is $clog2(TICK_DIV) bits.

## Timing
- Reset values: `step`=0, `busy`=0, `step_done`=0, `seq_done`=0, state=IDLE.
- All outputs are registered.
- `start` at edge N:
  - `busy`=1 after edge N (LOAD).
  - RUN after edge N+1.
- Dwell D with no pause lasts exactly D·TICK_DIV cycles in RUN. `step_done` rises on the edge where the final tick is consumed.
- `step` changes on the same edge that `step_done` rises; the pulse lasts exactly 1 cycle.
- Step-to-step overhead is 1 cycle (LOAD).
- Skip latency: `skip` sampled at edge N ends the step at edge N, with `step_done` high after edge N.
- Pause latency: pause takes effect at the first edge it is sampled. No tick is lost or duplicated across pause/resume.

## Structure
- Package `seq_pkg`:
  - `seq_state_t` enum (IDLE, LOAD, RUN, PAUSED).
  - `STEP_W`=4.
  - `DWELL_W`=4.
- Sub-module `tick_prescaler`:
  - Parameter TICK_DIV.
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `tick`, a one-cycle pulse at terminal count.
  - `en` low holds the count; `clr` zeroes it.
- `step_sequencer` instantiates one `tick_prescaler` and contains the FSM, `step` and `remaining` registers.

## Test plan
All scenarios use TICK_DIV=4 and NUM_STEPS=3.
- Basic run: `dwell`=2 for all steps, `loop`=0, pulse `start`.
  - `step` goes 0→1→2→0 with 8 RUN cycles per step.
  - 3 `step_done` pulses.
  - `seq_done` coincident with the third `step_done`.
  - `busy` drops after it.
- Zero dwell: `dwell`=0 on step 1.
  - Step 1 lasts 4 RUN cycles (treated as 1 s).
- Pause: assert `pause` for 10 cycles mid-step 0.
  - Step 0 lasts 8+10 cycles in RUN/PAUSED combined.
  - `step` is unchanged during the pause.
- Skip:
  - `skip` 2 cycles into step 1 gives `step_done` on that edge, `step`=2, with no wait for ticks.
  - `skip` together with `pause` behaves the same.
- Loop and re-start:
  - `loop`=1: `step` returns to 0 after `seq_done` and `busy` stays 1.
  - A `start` pulse while `busy` causes no change.
- Reset mid-run: assert `rst` asynchronously during step 2.
  - `step`=0, `busy`=0, pulses 0 without waiting for a clock edge.
  - A new `start` resumes normal operation.
